// File: rtl/jpeg_pixpack_pkg.sv
// rtl/jpeg_pixpack_pkg.sv - shared types and constants for the JPEG pixel packer
package jpeg_pixpack_pkg;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        rgb565_t     data;
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } pixel_t;

    typedef enum logic {
        ST_EMPTY     = 1'b0,
        ST_HOLD_EVEN = 1'b1
    } hold_state_t;

    // Ordered-dither thresholds indexed by {y[0], x[0]}, two bits per entry, entry 0 in the LSBs.
    localparam logic [7:0] DITHER_LUT = {2'd1, 2'd3, 2'd2, 2'd0};

    localparam logic [3:0] STRB_PAIR = 4'b1111;
    localparam logic [3:0] STRB_EVEN = 4'b0011;
    localparam logic [3:0] STRB_ODD  = 4'b1100;

endpackage

// File: rtl/jpeg_pixel_packer_if.sv
// rtl/jpeg_pixel_packer_if.sv - pixel input stream and framebuffer write stream of the packer
interface jpeg_pixel_packer_if;

    logic        pixel_valid_i;
    logic        pixel_accept_o;
    logic [15:0] pixel_width_i;
    logic [15:0] pixel_height_i;
    logic [15:0] pixel_x_i;
    logic [15:0] pixel_y_i;
    logic [7:0]  pixel_r_i;
    logic [7:0]  pixel_g_i;
    logic [7:0]  pixel_b_i;

    logic        wr_valid_o;
    logic        wr_accept_i;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_strb_o;

    modport slave (
        input  pixel_valid_i, pixel_width_i, pixel_height_i, pixel_x_i, pixel_y_i,
        input  pixel_r_i, pixel_g_i, pixel_b_i,
        output pixel_accept_o,
        output wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o,
        input  wr_accept_i
    );

    modport master (
        output pixel_valid_i, pixel_width_i, pixel_height_i, pixel_x_i, pixel_y_i,
        output pixel_r_i, pixel_g_i, pixel_b_i,
        input  pixel_accept_o,
        input  wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o,
        output wr_accept_i
    );

endinterface

// File: rtl/jpeg_pixpack_rgb565.sv
// rtl/jpeg_pixpack_rgb565.sv - combinational RGB888 to RGB565 conversion
// Optional 2x2 ordered dither before truncation when JPEG_PIXPACK_DITHER_EN is defined.
module jpeg_pixpack_rgb565
    import jpeg_pixpack_pkg::*;
(
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    input  logic       i_x0,
    input  logic       i_y0,
    output rgb565_t    o_rgb
);

`ifdef JPEG_PIXPACK_DITHER_EN
    logic [2:0] w_idx;
    logic [1:0] w_t;
    logic [8:0] w_r_sum, w_g_sum, w_b_sum;
    logic [7:0] w_r, w_g, w_b;
    logic       w_unused;

    assign w_idx   = {i_y0, i_x0, 1'b0};
    assign w_t     = DITHER_LUT[w_idx +: 2];
    assign w_r_sum = {1'b0, i_r} + {6'd0, w_t, 1'b0};
    assign w_g_sum = {1'b0, i_g} + {7'd0, w_t};
    assign w_b_sum = {1'b0, i_b} + {6'd0, w_t, 1'b0};
    // Saturate so bright channels never wrap to black.
    assign w_r     = w_r_sum[8] ? 8'hFF : w_r_sum[7:0];
    assign w_g     = w_g_sum[8] ? 8'hFF : w_g_sum[7:0];
    assign w_b     = w_b_sum[8] ? 8'hFF : w_b_sum[7:0];
    assign o_rgb   = {w_r[7:3], w_g[7:2], w_b[7:3]};
    assign w_unused = ^{w_r[2:0], w_g[1:0], w_b[2:0]};
`else
    logic w_unused;

    assign o_rgb    = {i_r[7:3], i_g[7:2], i_b[7:3]};
    assign w_unused = ^{i_r[2:0], i_g[1:0], i_b[2:0], i_x0, i_y0};
`endif

endmodule

// File: rtl/jpeg_pixel_packer.sv
// rtl/jpeg_pixel_packer.sv - packs MCU-ordered pixels into RGB565 pair words for a raster framebuffer
// Optional ordered dither selected by JPEG_PIXPACK_DITHER_EN.
module jpeg_pixel_packer
    import jpeg_pixpack_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        fb_base_i,
    input  logic [15:0]        fb_stride_i,
    jpeg_pixel_packer_if.slave bus,
    output logic               frame_done_o,
    output logic               busy_o
);

    logic              r_run, r_in_frame;
    logic [CNT_W-1:0]  r_count, r_total, w_total;
    logic [ADDR_W-1:0] r_base, w_base, w_addr;
    logic [15:0]       r_stride, w_stride;
    logic [31:0]       w_area;
    logic              w_take, w_last, w_drop, w_accept;
    rgb565_t           w_rgb;

    pixel_t            r_s1, r_hold;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr, r_hold_addr;
    hold_state_t       r_state;

    logic              r_wr_valid, r_wr_last, r_frame_done;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic [3:0]        r_wr_strb;

    logic              w_advance, w_emit, w_emit_last, w_to_hold, w_pair;
    logic [ADDR_W-1:0] w_emit_addr;
    logic [31:0]       w_emit_data;
    logic [3:0]        w_emit_strb;

    jpeg_pixpack_rgb565 u_rgb565 (
        .i_r   (bus.pixel_r_i),
        .i_g   (bus.pixel_g_i),
        .i_b   (bus.pixel_b_i),
        .i_x0  (bus.pixel_x_i[0]),
        .i_y0  (bus.pixel_y_i[0]),
        .o_rgb (w_rgb)
    );

    // Frame geometry comes straight from the inputs for the first pixel, from the latches afterwards.
    assign w_area   = 32'(bus.pixel_width_i) * 32'(bus.pixel_height_i);
    assign w_total  = r_in_frame ? r_total  : CNT_W'(w_area);
    assign w_base   = r_in_frame ? r_base   : ADDR_W'(fb_base_i);
    assign w_stride = r_in_frame ? r_stride : fb_stride_i;
    assign w_addr   = w_base + ADDR_W'(32'(bus.pixel_y_i) * 32'(w_stride))
                    + ADDR_W'({bus.pixel_x_i[15:1], 2'b00});
    assign w_drop   = (w_total == '0);
    assign w_last   = (r_count == w_total - 1'b1);

    assign w_accept = r_run & (~r_s1_valid | w_advance);
    assign w_take   = bus.pixel_valid_i & w_accept;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_run      <= 1'b0;
            r_in_frame <= 1'b0;
            r_count    <= '0;
            r_total    <= '0;
            r_base     <= '0;
            r_stride   <= '0;
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s1_addr  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_take && !w_drop) begin
                if (w_last) begin
                    r_in_frame <= 1'b0;
                    r_count    <= '0;
                end else begin
                    r_in_frame <= 1'b1;
                    r_count    <= r_count + 1'b1;
                end
                if (!r_in_frame) begin
                    r_total  <= w_total;
                    r_base   <= w_base;
                    r_stride <= w_stride;
                end
                r_s1_valid <= 1'b1;
                r_s1       <= '{data: w_rgb, x: bus.pixel_x_i, y: bus.pixel_y_i, last: w_last};
                r_s1_addr  <= w_addr;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign w_pair = (r_s1.x == r_hold.x + 16'd1) && (r_s1.y == r_hold.y);

    // Emission is gated by the registered output valid only, keeping wr_accept_i off the accept path.
    always_comb begin
        w_advance   = 1'b0;
        w_emit      = 1'b0;
        w_to_hold   = 1'b0;
        w_emit_last = 1'b0;
        w_emit_addr = r_s1_addr;
        w_emit_data = '0;
        w_emit_strb = STRB_EVEN;
        if (r_s1_valid) begin
            if (r_state == ST_EMPTY) begin
                if (!r_s1.x[0] && !r_s1.last) begin
                    w_advance = 1'b1;
                    w_to_hold = 1'b1;
                end else if (!r_wr_valid) begin
                    w_advance   = 1'b1;
                    w_emit      = 1'b1;
                    w_emit_last = r_s1.last;
                    if (r_s1.x[0]) begin
                        w_emit_data = {r_s1.data, 16'h0000};
                        w_emit_strb = STRB_ODD;
                    end else begin
                        w_emit_data = {16'h0000, r_s1.data};
                    end
                end
            end else if (!r_wr_valid) begin
                w_emit      = 1'b1;
                w_emit_addr = r_hold_addr;
                if (w_pair) begin
                    w_advance   = 1'b1;
                    w_emit_data = {r_s1.data, r_hold.data};
                    w_emit_strb = STRB_PAIR;
                    w_emit_last = r_s1.last;
                end else begin
                    // Flush the lone even pixel; the new one is reconsidered next cycle from EMPTY.
                    w_emit_data = {16'h0000, r_hold.data};
                    w_emit_last = r_hold.last;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_EMPTY;
            r_hold       <= '0;
            r_hold_addr  <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_strb    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_to_hold) begin
                r_state     <= ST_HOLD_EVEN;
                r_hold      <= r_s1;
                r_hold_addr <= r_s1_addr;
            end else if (w_emit && r_state == ST_HOLD_EVEN) begin
                r_state <= ST_EMPTY;
            end
            if (w_emit) begin
                r_wr_valid <= 1'b1;
                r_wr_last  <= w_emit_last;
                r_wr_addr  <= w_emit_addr;
                r_wr_data  <= w_emit_data;
                r_wr_strb  <= w_emit_strb;
            end else if (bus.wr_accept_i) begin
                r_wr_valid <= 1'b0;
            end
            r_frame_done <= r_wr_valid & bus.wr_accept_i & r_wr_last;
        end
    end

    assign bus.pixel_accept_o = w_accept;
    assign bus.wr_valid_o     = r_wr_valid;
    assign bus.wr_addr_o      = 32'(r_wr_addr);
    assign bus.wr_data_o      = r_wr_data;
    assign bus.wr_strb_o      = r_wr_strb;
    assign frame_done_o       = r_frame_done;
    assign busy_o             = r_s1_valid | (r_state == ST_HOLD_EVEN) | r_wr_valid | r_in_frame;

endmodule

// File: tb/tb_jpeg_pixel_packer.sv
// tb/tb_jpeg_pixel_packer.sv - directed self-checking bench for jpeg_pixel_packer
module tb_jpeg_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fb_base = 32'h1000;
    logic [15:0] fb_stride = 16'd8;
    logic        frame_done, busy;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [3:0]  q_strb[$];
    int          q_cyc[$];
    int          q_done[$];

    jpeg_pixel_packer_if bus();

    jpeg_pixel_packer dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .fb_base_i    (fb_base),
        .fb_stride_i  (fb_stride),
        .bus          (bus),
        .frame_done_o (frame_done),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_valid_o && bus.wr_accept_i) begin
                q_addr.push_back(bus.wr_addr_o);
                q_data.push_back(bus.wr_data_o);
                q_strb.push_back(bus.wr_strb_o);
                q_cyc.push_back(cyc);
            end
            if (frame_done) q_done.push_back(cyc);
        end
    end

    task automatic do_reset(input logic [15:0] w, input logic [15:0] h);
        rst_n = 1'b0;
        bus.pixel_valid_i  = 1'b0;
        bus.wr_accept_i    = 1'b1;
        bus.pixel_width_i  = w;
        bus.pixel_height_i = h;
        fb_base   = 32'h1000;
        fb_stride = 16'd8;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q_addr.delete(); q_data.delete(); q_strb.delete(); q_cyc.delete(); q_done.delete();
        @(posedge clk); #1;
    endtask

    task automatic send_pixel(input logic [15:0] x, input logic [15:0] y,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              output int t_acc);
        int n = 0;
        bus.pixel_x_i = x; bus.pixel_y_i = y;
        bus.pixel_r_i = r; bus.pixel_g_i = g; bus.pixel_b_i = b;
        bus.pixel_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.pixel_accept_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_acc = cyc;
        checks++;
        if (bus.pixel_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout x=%0d y=%0d: accept=%b required 1", x, y, bus.pixel_accept_o);
        end
        @(posedge clk); #1;
        bus.pixel_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.pixel_valid_i = 1'b1;
        bus.wr_accept_i = 1'b1;
        bus.pixel_width_i = 16'd4; bus.pixel_height_i = 16'd2;
        bus.pixel_x_i = '0; bus.pixel_y_i = '0;
        bus.pixel_r_i = '0; bus.pixel_g_i = '0; bus.pixel_b_i = '0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bus.wr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b required 0", bus.wr_valid_o); end
        if (bus.pixel_accept_o !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b required 0", bus.pixel_accept_o); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        bus.pixel_valid_i = 1'b0;
    endtask

    task automatic test_pair;
        int t0, t1;
        do_reset(16'd4, 16'd2);
        send_pixel(16'd0, 16'd0, 8'hFF, 8'h00, 8'h00, t0);
        send_pixel(16'd1, 16'd0, 8'h00, 8'hFF, 8'h00, t1);
        repeat (6) @(posedge clk); #1;
        checks++;
        if (q_addr.size() != 1) begin errors++; $display("FAIL pair_count: got %0d required 1", q_addr.size()); end
        if (q_addr.size() >= 1) begin
            checks += 4;
            if (q_addr[0] !== 32'h1000) begin errors++; $display("FAIL pair_addr: got %h required 00001000", q_addr[0]); end
            if (q_data[0] !== 32'h07E0F800) begin errors++; $display("FAIL pair_data: got %h required 07e0f800", q_data[0]); end
            if (q_strb[0] !== 4'b1111) begin errors++; $display("FAIL pair_strb: got %b required 1111", q_strb[0]); end
            if (q_cyc[0] - t1 != 2) begin errors++; $display("FAIL pair_latency: got %0d required 2", q_cyc[0] - t1); end
        end
    endtask

    task automatic test_flush;
        int t;
        logic [31:0] exp_addr[3];
        logic [31:0] exp_data[3];
        logic [3:0]  exp_strb[3];
        exp_addr = '{32'h1004, 32'h1008, 32'h100C};
        exp_data = '{32'h0000F81F, 32'h0000FFFF, 32'h001F0000};
        exp_strb = '{4'b0011, 4'b0011, 4'b1100};
        do_reset(16'd4, 16'd2);
        send_pixel(16'd2, 16'd0, 8'hFF, 8'h00, 8'hFF, t);
        send_pixel(16'd0, 16'd1, 8'hFF, 8'hFF, 8'hFF, t);
        send_pixel(16'd3, 16'd1, 8'h00, 8'h00, 8'hFF, t);
        repeat (8) @(posedge clk); #1;
        checks++;
        if (q_addr.size() != 3) begin errors++; $display("FAIL flush_count: got %0d required 3", q_addr.size()); end
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checks += 3;
            if (q_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL flush_addr[%0d]: got %h required %h", i, q_addr[i], exp_addr[i]); end
            if (q_data[i] !== exp_data[i]) begin errors++; $display("FAIL flush_data[%0d]: got %h required %h", i, q_data[i], exp_data[i]); end
            if (q_strb[i] !== exp_strb[i]) begin errors++; $display("FAIL flush_strb[%0d]: got %b required %b", i, q_strb[i], exp_strb[i]); end
        end
    endtask

    task automatic test_odd_first;
        int t;
        do_reset(16'd4, 16'd2);
        send_pixel(16'd3, 16'd0, 8'hFF, 8'h00, 8'h00, t);
        repeat (5) @(posedge clk); #1;
        checks++;
        if (q_addr.size() != 1) begin errors++; $display("FAIL odd_count: got %0d required 1", q_addr.size()); end
        if (q_addr.size() >= 1) begin
            checks += 4;
            if (q_addr[0] !== 32'h1004) begin errors++; $display("FAIL odd_addr: got %h required 00001004", q_addr[0]); end
            if (q_data[0][31:16] !== 16'hF800) begin errors++; $display("FAIL odd_data: got %h required f800", q_data[0][31:16]); end
            if (q_strb[0] !== 4'b1100) begin errors++; $display("FAIL odd_strb: got %b required 1100", q_strb[0]); end
            if (q_cyc[0] - t != 2) begin errors++; $display("FAIL odd_latency: got %0d required 2", q_cyc[0] - t); end
        end
    endtask

    task automatic test_single;
        int t;
        do_reset(16'd1, 16'd1);
        send_pixel(16'd0, 16'd0, 8'h00, 8'hFF, 8'h00, t);
        repeat (6) @(posedge clk); #1;
        checks += 3;
        if (q_addr.size() != 1) begin errors++; $display("FAIL single_count: got %0d required 1", q_addr.size()); end
        if (q_done.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", q_done.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b required 0", busy); end
        if (q_addr.size() >= 1) begin
            checks += 3;
            if (q_addr[0] !== 32'h1000) begin errors++; $display("FAIL single_addr: got %h required 00001000", q_addr[0]); end
            if (q_data[0] !== 32'h000007E0) begin errors++; $display("FAIL single_data: got %h required 000007e0", q_data[0]); end
            if (q_strb[0] !== 4'b0011) begin errors++; $display("FAIL single_strb: got %b required 0011", q_strb[0]); end
            if (q_done.size() >= 1) begin
                checks++;
                if (q_done[0] != q_cyc[0] + 1) begin errors++; $display("FAIL single_done_timing: got cycle %0d required %0d", q_done[0], q_cyc[0] + 1); end
            end
        end
    endtask

    task automatic test_zero_size;
        int t;
        do_reset(16'd0, 16'd5);
        for (int i = 0; i < 3; i++) send_pixel(16'(i), 16'd0, 8'hFF, 8'hFF, 8'hFF, t);
        repeat (5) @(posedge clk); #1;
        checks += 3;
        if (q_addr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d required 0", q_addr.size()); end
        if (q_done.size() != 0) begin errors++; $display("FAIL zero_done: got %0d required 0", q_done.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] cap_addr, cap_data;
        logic        have, unstable;
        have = 1'b0;
        unstable = 1'b0;
        do_reset(16'd4, 16'd2);
        bus.wr_accept_i = 1'b0;
        fork
            begin
                int t;
                for (int i = 0; i < 8; i++) begin
                    if (i % 2 == 0) send_pixel(16'(i % 4), 16'(i / 4), 8'hFF, 8'h00, 8'h00, t);
                    else            send_pixel(16'(i % 4), 16'(i / 4), 8'h00, 8'h00, 8'hFF, t);
                end
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (bus.wr_valid_o) begin
                        if (!have) begin
                            have = 1'b1;
                            cap_addr = bus.wr_addr_o;
                            cap_data = bus.wr_data_o;
                        end else if (bus.wr_addr_o !== cap_addr || bus.wr_data_o !== cap_data) begin
                            unstable = 1'b1;
                        end
                    end
                end
                checks += 3;
                if (bus.pixel_accept_o !== 1'b0) begin errors++; $display("FAIL stall_accept: got %b required 0", bus.pixel_accept_o); end
                if (!have) begin errors++; $display("FAIL stall_valid: got no write valid, required one"); end
                if (unstable) begin errors++; $display("FAIL stall_stable: got changing word, required %h/%h held", cap_addr, cap_data); end
                @(posedge clk); #1;
                bus.wr_accept_i = 1'b1;
            end
        join
        repeat (15) @(posedge clk); #1;
        checks += 2;
        if (q_addr.size() != 4) begin errors++; $display("FAIL bp_count: got %0d required 4", q_addr.size()); end
        if (q_done.size() != 1) begin errors++; $display("FAIL bp_done: got %0d required 1", q_done.size()); end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            checks += 3;
            if (q_addr[i] !== 32'h1000 + 32'(i * 4)) begin errors++; $display("FAIL bp_addr[%0d]: got %h required %h", i, q_addr[i], 32'h1000 + 32'(i * 4)); end
            if (q_data[i] !== 32'h001FF800) begin errors++; $display("FAIL bp_data[%0d]: got %h required 001ff800", i, q_data[i]); end
            if (q_strb[i] !== 4'b1111) begin errors++; $display("FAIL bp_strb[%0d]: got %b required 1111", i, q_strb[i]); end
        end
    endtask

    task automatic test_dither;
        int t;
        logic [31:0] exp;
`ifdef JPEG_PIXPACK_DITHER_EN
        exp = 32'hF8000800;
`else
        exp = 32'hF8000000;
`endif
        do_reset(16'd2, 16'd2);
        fb_base = 32'h0;
        fb_stride = 16'd4;
        send_pixel(16'd0, 16'd1, 8'h05, 8'h00, 8'h00, t);
        send_pixel(16'd1, 16'd1, 8'hFF, 8'h00, 8'h00, t);
        repeat (5) @(posedge clk); #1;
        checks++;
        if (q_addr.size() != 1) begin errors++; $display("FAIL dither_count: got %0d required 1", q_addr.size()); end
        if (q_addr.size() >= 1) begin
            checks += 2;
            if (q_addr[0] !== 32'h4) begin errors++; $display("FAIL dither_addr: got %h required 00000004", q_addr[0]); end
            if (q_data[0] !== exp) begin errors++; $display("FAIL dither_data: got %h required %h", q_data[0], exp); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int t;
        do_reset(16'd4, 16'd2);
        send_pixel(16'd0, 16'd0, 8'hFF, 8'hFF, 8'hFF, t);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b required 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (bus.wr_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", bus.wr_valid_o); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_pixel(16'd1, 16'd0, 8'h00, 8'hFF, 8'h00, t);
        repeat (5) @(posedge clk); #1;
        checks++;
        if (q_addr.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d required 1", q_addr.size()); end
        if (q_addr.size() >= 1) begin
            checks += 2;
            if (q_strb[0] !== 4'b1100) begin errors++; $display("FAIL midrst_strb: got %b required 1100", q_strb[0]); end
            if (q_data[0] !== 32'h07E00000) begin errors++; $display("FAIL midrst_data: got %h required 07e00000", q_data[0]); end
        end
    endtask

    initial begin
        test_reset;
        test_pair;
        test_flush;
        test_odd_first;
        test_single;
        test_zero_size;
        test_back_to_back;
        test_dither;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
